// File: rtl/fetch_buffer8w_if.sv
// fetch_buffer8w_if: fetch-side packet and decoder-side lane bundle for fetch_buffer8w
interface fetch_buffer8w_if;
  logic             fetch_valid_i;
  logic [3:0]       fetch_count_i;
  logic [7:0][31:0] fetch_instr_i;
  logic [63:0]      fetch_pc_i;
  logic             fetch_ready_o;
  logic [7:0]       dec_valid_o;
  logic [7:0][31:0] dec_instr_o;
  logic [7:0][63:0] dec_pc_o;
  logic             dec_ready_i;
  modport master (
    output fetch_valid_i, fetch_count_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o
  );
  modport slave (
    input  fetch_valid_i, fetch_count_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o
  );
endinterface

// File: rtl/fetch_buffer8w.sv
// fetch_buffer8w: circular instr/PC FIFO, up to 8 words in and 8 aligned lanes out per cycle
module fetch_buffer8w #(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  fetch_buffer8w_if.slave        bus,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   r_instr [DEPTH];
  logic [63:0]   r_pc    [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_count;
  logic [3:0]    w_n, w_m;
  logic          w_push, w_pop;
  logic [AW-1:0] w_idx [8];
  assign w_n = (bus.fetch_count_i > 4'd8) ? 4'd8 : bus.fetch_count_i;
  assign w_m = (r_count >= (AW+1)'(8)) ? 4'd8 : 4'(r_count);
  // ready looks only at registered occupancy, so it never depends on dec_ready_i
  assign bus.fetch_ready_o = r_count <= (AW+1)'(DEPTH - 8);
  assign w_push = bus.fetch_valid_i && bus.fetch_ready_o && !flush_i;
  assign w_pop = bus.dec_ready_i && !flush_i;
  assign count_o = r_count;
  always_ff @(posedge clk)
    for (int k = 0; k < 8; k++)
      if (w_push && 4'(k) < w_n) begin
        r_instr[r_wr + AW'(k)] <= bus.fetch_instr_i[k];
        r_pc[r_wr + AW'(k)] <= bus.fetch_pc_i + 64'(4 * k);
      end
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(w_n);
      if (w_pop) r_rd <= r_rd + AW'(w_m);
      r_count <= r_count + (AW+1)'(w_push ? w_n : 4'd0) - (AW+1)'(w_pop ? w_m : 4'd0);
    end
  end
  always_comb
    for (int k = 0; k < 8; k++) begin
      w_idx[k] = r_rd + AW'(k);
      bus.dec_valid_o[k] = 4'(k) < w_m;
      bus.dec_instr_o[k] = bus.dec_valid_o[k] ? r_instr[w_idx[k]] : '0;
      bus.dec_pc_o[k] = bus.dec_valid_o[k] ? r_pc[w_idx[k]] : '0;
    end
  a_count_le8: assert property (@(posedge clk) disable iff (!rst_n)
    bus.fetch_valid_i && bus.fetch_ready_o && !flush_i |-> bus.fetch_count_i <= 4'd8);
endmodule
